reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter MAX_ADDRESS, default 4, meaning highest valid register address.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port a_req  input  1  requester A (SPI frame decoder) write request, held until a_ack.
REQ-005 SHALL have port a_addr  input  7  requester A register address.
REQ-006 SHALL have port a_data  input  8  requester A write data.
REQ-007 SHALL have port a_ack  output  1  one-cycle completion pulse to A.
REQ-008 SHALL have port a_err  output  1  valid with a_ack; address exceeded MAX_ADDRESS.
REQ-009 SHALL have ports b_req, b_addr, b_data, b_ack, b_err, identical to the A ports, for requester B (on-chip sequencer).
REQ-010 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  register bank at addresses 0..4.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, COMMIT, ACK; IDLE->COMMIT when a_req or b_req is high; COMMIT->ACK unconditionally; ACK->IDLE unconditionally.
REQ-013 SHALL, in IDLE with exactly one req high, grant that requester.
REQ-014 SHALL, in IDLE with both req high, grant the requester not granted last (round-robin); after reset, A wins the first tie.
REQ-015 SHALL, on the IDLE->COMMIT edge, latch the winner's id, addr and data; later changes on inputs are ignored until the next IDLE.
REQ-016 SHALL, in COMMIT, write the latched data into the addressed register at the clock edge leaving COMMIT if addr <= MAX_ADDRESS; otherwise no register changes.
REQ-017 SHALL assert exactly the winner's ack for the single cycle spent in ACK, with err high in that cycle iff addr > MAX_ADDRESS; the loser's ack and err stay low.
REQ-018 SHALL update the last-grant pointer on the IDLE->COMMIT edge.
REQ-019 SHALL ignore req in COMMIT and ACK; a requester drops or re-arms req at the edge ending its ack cycle, so a request re-armed there is seen in the following IDLE cycle.
REQ-020 SHALL give latency: req high in IDLE at cycle n -> register updated and ack high in cycle n+2 -> IDLE in cycle n+3; throughput one write per 3 cycles.
REQ-021 SHALL let a waiting loser keep req high; it wins the next IDLE cycle, 3 cycles after the first grant.
REQ-022 SHALL keep all register outputs unchanged except by a committed valid write; an address 0..4 maps to the registers in the order listed in REQ-010.
REQ-023 SHALL make busy, ack and err registered outputs with no combinational path from any input.

Reset
REQ-024 SHALL, on a clock edge with rst_n low, force state IDLE, all five registers 8'h00, acks/errs/busy 0, and last-grant pointer to B (so A wins the next tie).
REQ-025 SHALL abandon a transaction in COMMIT or ACK when reset occurs: no write, no ack; the requester must re-request.

Structure
REQ-026 SHALL place the FSM state encoding, register address constants (0..4) and the default MAX_ADDRESS in a shared package.
REQ-027 SHALL contain one sub-module, rr_pick2, a 2-way round-robin picker (inputs two reqs + last grant, outputs grant id); the rest stays flat.

Verification
REQ-028 SHALL cover: A alone writes addr 4, data 8'h80 -> pwm_duty_cycle=8'h80 and a_ack high exactly 2 cycles after req, a_err=0, busy high for 2 cycles.
REQ-029 SHALL cover: A and B both request from reset (A addr 0 data 8'hF0, B addr 0 data 8'h0F) -> A committed first, B 3 cycles later; final en_reg_out_7_0=8'h0F.
REQ-030 SHALL cover: A and B both hold req for 4 consecutive grants -> grant order A,B,A,B, acks never overlap.
REQ-031 SHALL cover: B writes addr 7'd5, data 8'hFF -> b_ack and b_err high together, all registers unchanged.
REQ-032 SHALL cover: reset asserted during COMMIT of A addr 2, data 8'h55 -> en_reg_pwm_7_0=8'h00, no a_ack, FSM IDLE.
REQ-033 SHALL cover: inputs changed during COMMIT (A addr 1, 8'h3C latched, then a_data changed to 8'hAA) -> en_reg_out_15_8=8'h3C.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter:
// FSM encoding, register bank addresses and default address limit.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    localparam int DEF_MAX_ADDRESS = 4;

    localparam logic [6:0] ADDR_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY   = 7'd4;

endpackage

// File: rtl/reg_write_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// Ports: req_a/req_b requests, last_b (last grant went to B), grant_b (1 = B wins).
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic grant_b
);

    // B wins when alone, or on a tie when A was served last.
    assign grant_b = req_b & (~req_a | ~last_b);

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates register writes from two requesters into a 5-byte bank.
// Ports: clk, rst_n (sync, active-low), a_/b_ req/addr/data/ack/err, bank outputs, busy.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int MAX_ADDRESS = DEF_MAX_ADDRESS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ack,
    output logic       a_err,
    input  logic       b_req,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic       b_err,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       busy
);

    localparam logic [6:0] MAX_A = 7'(MAX_ADDRESS);

    arb_state_t state;
    logic       last_b;
    logic       grant_b;
    logic       lat_b;
    logic [6:0] lat_addr;
    logic [7:0] lat_data;
    logic       addr_err;

    rr_pick2 u_pick (
        .req_a   (a_req),
        .req_b   (b_req),
        .last_b  (last_b),
        .grant_b (grant_b)
    );

    assign addr_err = lat_addr > MAX_A;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_b          <= 1'b1;
            lat_b           <= 1'b0;
            lat_addr        <= '0;
            lat_data        <= '0;
            a_ack           <= 1'b0;
            a_err           <= 1'b0;
            b_ack           <= 1'b0;
            b_err           <= 1'b0;
            busy            <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state    <= COMMIT;
                        busy     <= 1'b1;
                        lat_b    <= grant_b;
                        last_b   <= grant_b;
                        lat_addr <= grant_b ? b_addr : a_addr;
                        lat_data <= grant_b ? b_data : a_data;
                    end
                end
                COMMIT: begin
                    state <= ACK;
                    if (!addr_err) begin
                        case (lat_addr)
                            ADDR_OUT_LO: en_reg_out_7_0  <= lat_data;
                            ADDR_OUT_HI: en_reg_out_15_8 <= lat_data;
                            ADDR_PWM_LO: en_reg_pwm_7_0  <= lat_data;
                            ADDR_PWM_HI: en_reg_pwm_15_8 <= lat_data;
                            ADDR_DUTY:   pwm_duty_cycle  <= lat_data;
                            default: ;
                        endcase
                    end
                    if (lat_b) begin
                        b_ack <= 1'b1;
                        b_err <= addr_err;
                    end else begin
                        a_ack <= 1'b1;
                        a_err <= addr_err;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios plus random
// request traffic checked against a transaction-level model.
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, b_req;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ack, a_err, b_ack, b_err, busy;
    logic [7:0] r0, r1, r2, r3, r4;

    int errors = 0;
    int checks = 0;

    // Model state: register contents and who was granted last.
    logic [7:0] mreg [5];
    bit         m_last_b;

    reg_write_arbiter #(.MAX_ADDRESS(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_req           (a_req),
        .a_addr          (a_addr),
        .a_data          (a_data),
        .a_ack           (a_ack),
        .a_err           (a_err),
        .b_req           (b_req),
        .b_addr          (b_addr),
        .b_data          (b_data),
        .b_ack           (b_ack),
        .b_err           (b_err),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] model_regs();
        return {mreg[0], mreg[1], mreg[2], mreg[3], mreg[4]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
        m_last_b = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one grant starting in an IDLE cycle (called #1 after an edge).
    // Optionally rewrites the winner's inputs while the write is in flight.
    task automatic serve(input bit scramble, input logic [7:0] sdata,
                         output bit won_b);
        bit         wb;
        logic [6:0] ad;
        logic [7:0] dt;
        bit         bad;
        wb  = (a_req && b_req) ? !m_last_b : b_req;
        ad  = wb ? b_addr : a_addr;
        dt  = wb ? b_data : a_data;
        bad = ad > 7'd4;
        chk("idle_busy", busy, 0);
        chk("idle_acks", {a_ack, b_ack}, 0);
        step();
        chk("commit_busy", busy, 1);
        chk("commit_acks", {a_ack, b_ack, a_err, b_err}, 0);
        chk("commit_regs", {r0, r1, r2, r3, r4}, model_regs());
        if (scramble) begin
            if (wb) begin
                b_data = sdata;
                b_addr = 7'($urandom_range(0, 6));
            end else begin
                a_data = sdata;
                a_addr = 7'($urandom_range(0, 6));
            end
        end
        m_last_b = wb;
        if (!bad) mreg[ad] = dt;
        step();
        chk("ack_busy", busy, 1);
        chk("ack_win", wb ? b_ack : a_ack, 1);
        chk("ack_err", wb ? b_err : a_err, bad);
        chk("ack_lose", wb ? {a_ack, a_err} : {b_ack, b_err}, 0);
        chk("ack_regs", {r0, r1, r2, r3, r4}, model_regs());
        if (wb) b_req = 1'b0;
        else a_req = 1'b0;
        step();
        chk("post_busy", busy, 0);
        chk("post_acks", {a_ack, b_ack, a_err, b_err}, 0);
        won_b = wb;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit w;
        bit got [4];
        rst_n  = 1'b0;
        a_req  = 0; b_req  = 0;
        a_addr = 0; b_addr = 0;
        a_data = 0; b_data = 0;

        do_reset();
        chk("rst_regs", {r0, r1, r2, r3, r4}, 40'h0);
        chk("rst_flags", {busy, a_ack, a_err, b_ack, b_err}, 0);

        // Tie from reset: A first, B three cycles later.
        a_req = 1; a_addr = 7'd0; a_data = 8'hF0;
        b_req = 1; b_addr = 7'd0; b_data = 8'h0F;
        serve(0, 8'h00, w);
        chk("tie_first_a", w, 0);
        serve(0, 8'h00, w);
        chk("tie_second_b", w, 1);
        chk("tie_final", r0, 8'h0F);

        // A alone writes the duty-cycle register.
        a_req = 1; a_addr = 7'd4; a_data = 8'h80;
        serve(0, 8'h00, w);
        chk("duty_val", r4, 8'h80);

        // B writes beyond the bank: error, nothing changes.
        b_req = 1; b_addr = 7'd5; b_data = 8'hFF;
        serve(0, 8'h00, w);
        chk("err_winner_b", w, 1);

        // Inputs changing in flight must not affect the latched write.
        a_req = 1; a_addr = 7'd1; a_data = 8'h3C;
        serve(1, 8'hAA, w);
        chk("latch_val", r1, 8'h3C);

        // Reset during COMMIT abandons the write.
        a_req = 1; a_addr = 7'd2; a_data = 8'h55;
        step();
        chk("abort_commit", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_req = 1'b0;
        model_reset();
        chk("abort_busy", busy, 0);
        chk("abort_regs", {r0, r1, r2, r3, r4}, 40'h0);
        step();
        chk("abort_noack", {a_ack, a_err, busy}, 0);
        chk("abort_pwm", r2, 8'h00);

        // Both requesters hold for four grants: strict alternation.
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_addr = 7'(i); a_data = 8'(8'h10 + i);
            b_req = 1; b_addr = 7'(i + 1); b_data = 8'(8'h20 + i);
            if (i > 0) begin
                if (got[i-1]) a_req = a_req; else a_req = 1;
            end
            serve(0, 8'h00, w);
            got[i] = w;
        end
        chk("alt_order", {got[0], got[1], got[2], got[3]}, 4'b0101);
        a_req = 0; b_req = 0;
        step();

        // Random traffic; a pending loser keeps its request and values.
        for (int t = 0; t < 60; t++) begin
            if (!a_req && $urandom_range(0, 1) == 1) begin
                a_req  = 1;
                a_addr = 7'($urandom_range(0, 6));
                a_data = 8'($urandom);
            end
            if (!b_req && $urandom_range(0, 1) == 1) begin
                b_req  = 1;
                b_addr = 7'($urandom_range(0, 6));
                b_data = 8'($urandom);
            end
            if (!a_req && !b_req) begin
                step();
                chk("rnd_idle", {busy, a_ack, b_ack}, 0);
                chk("rnd_idle_regs", {r0, r1, r2, r3, r4}, model_regs());
            end else begin
                serve($urandom_range(0, 3) == 0, 8'($urandom), w);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
